// File: rtl/uarto_word_ser.sv
// Word-to-byte UART output sequencer: prefetches WORD_W-bit words into a small FIFO and strobes
// their bytes one at a time into uart_tx. Define UARTO_CHECKSUM_EN to append a per-word XOR byte.
module uarto_word_ser #(
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  parameter int ACK_TO     = 255
) (
  input  logic              clk_150_0,
  input  logic              reset,
  input  logic              start_req,
  input  logic              end_req,
  output logic              read_req,
  input  logic              read_vaild,
  input  logic [WORD_W-1:0] read_data,
  output logic [7:0]        datain_uarto,
  output logic              wrsig_uarto,
  input  logic              idle,
  output logic              busy,
  output logic [15:0]       words_sent
);

  localparam int NBYTES = WORD_W / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TO_W   = $clog2(ACK_TO + 1) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_NEXT} state_t;

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              read_req_q, read_req_d;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        data_q, data_d;
  logic              wrsig_q, wrsig_d;
  logic              busy_q, busy_d;
  logic [15:0]       words_q, words_d;

  logic              run, push, pop, last_byte;
  logic [7:0]        cur_byte;
  logic [WORD_W-1:0] head_word, shifted_word;

`ifdef UARTO_CHECKSUM_EN
  logic [7:0] cks_q, cks_d;
  logic       cks_phase_q, cks_phase_d;

  function automatic logic [7:0] xor_bytes(input logic [WORD_W-1:0] w);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < NBYTES; i++) acc = acc ^ w[i*8 +: 8];
    return acc;
  endfunction
`endif

  assign run          = start_req & ~end_req;
  // A handshake is honoured even in the cycle run falls, since read_req_q is still high.
  assign push         = read_req_q & read_vaild;
  assign pop          = (state_q == S_IDLE) & run & (count_q != '0);
  assign head_word    = fifo_mem[rd_ptr_q];
  assign last_byte    = (idx_q == IDX_W'(NBYTES - 1));
  assign cur_byte     = (MSB_FIRST != 0) ? shreg_q[WORD_W-1 -: 8] : shreg_q[7:0];
  assign shifted_word = (MSB_FIRST != 0) ? (shreg_q << 8) : (shreg_q >> 8);

  always_ff @(posedge clk_150_0) begin
    if (push) fifo_mem[wr_ptr_q] <= read_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Looking at the post-update count keeps read_req low whenever the FIFO is full.
    read_req_d = run & ~push & (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    data_d   = data_q;
    wrsig_d  = 1'b0;
    words_d  = words_q;
`ifdef UARTO_CHECKSUM_EN
    cks_d       = cks_q;
    cks_phase_d = cks_phase_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shreg_d = head_word;
          idx_d   = '0;
          state_d = S_WAIT;
`ifdef UARTO_CHECKSUM_EN
          cks_d       = xor_bytes(head_word);
          cks_phase_d = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        if (idle) begin
          data_d = cur_byte;
`ifdef UARTO_CHECKSUM_EN
          if (cks_phase_q) data_d = cks_q;
`endif
          wrsig_d  = 1'b1;
          to_cnt_d = TO_W'(1);
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        // The count includes the strobe cycle, so an idle that never drops costs ACK_TO+2 cycles.
        if (!idle || (to_cnt_q == TO_W'(ACK_TO))) state_d = S_NEXT;
        else                                      to_cnt_d = to_cnt_q + TO_W'(1);
      end
      S_NEXT: begin
`ifdef UARTO_CHECKSUM_EN
        if (cks_phase_q) begin
          words_d = words_q + 16'd1;
          state_d = S_IDLE;
        end else if (last_byte) begin
          cks_phase_d = 1'b1;
          state_d     = S_WAIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shreg_d = shifted_word;
          state_d = S_WAIT;
        end
`else
        if (last_byte) begin
          words_d = words_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          shreg_d = shifted_word;
          state_d = S_WAIT;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) | (count_d != '0);
  end

  always_ff @(posedge clk_150_0 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      read_req_q <= 1'b0;
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      to_cnt_q   <= '0;
      data_q     <= 8'h00;
      wrsig_q    <= 1'b0;
      busy_q     <= 1'b0;
      words_q    <= 16'h0000;
`ifdef UARTO_CHECKSUM_EN
      cks_q       <= 8'h00;
      cks_phase_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      read_req_q <= read_req_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      wrsig_q    <= wrsig_d;
      busy_q     <= busy_d;
      words_q    <= words_d;
`ifdef UARTO_CHECKSUM_EN
      cks_q       <= cks_d;
      cks_phase_q <= cks_phase_d;
`endif
    end
  end

  assign read_req     = read_req_q;
  assign datain_uarto = data_q;
  assign wrsig_uarto  = wrsig_q;
  assign busy         = busy_q;
  assign words_sent   = words_q;

endmodule

// File: tb/tb_uarto_word_ser.sv
// Self-checking bench for uarto_word_ser: a 16-bit MSB-first instance with store/transmitter
// responders and a byte scoreboard, plus a 32-bit LSB-first instance for byte ordering.
module tb_uarto_word_ser;
  localparam int DEPTH = 4;
  localparam int ACK16 = 255;
  localparam int ACK32 = 3;
`ifdef UARTO_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  logic        clk_150_0 = 1'b0;
  logic        reset;
  logic        start_req, end_req, read_req, read_vaild, wrsig_uarto, idle, busy;
  logic [15:0] read_data, words_sent;
  logic [7:0]  datain_uarto;

  logic        start32, end32, read_req32, vaild32, wrsig32, idle32, busy32;
  logic [31:0] data32;
  logic [7:0]  datain32;
  logic [15:0] words32;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp32_q[$];
  logic [15:0] store_q[$];
  int  hs_cnt = 0, hs_cyc = 0;
  int  strobe_cnt = 0, last_strobe_cyc = 0, prev_strobe_cyc = 0, strobe32_cnt = 0;
  int  tx_mode = 0;
  int  words_exp = 0;
  bit  spurious = 1'b0;
  bit  prev_wr16 = 1'b0, prev_wr32 = 1'b0;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  cks;
  } vec_t;
  vec_t vecs[6];

  always #5 clk_150_0 = ~clk_150_0;
  always @(posedge clk_150_0) cyc <= cyc + 1;

  uarto_word_ser #(.WORD_W(16), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1), .ACK_TO(ACK16)) dut16 (
    .clk_150_0(clk_150_0), .reset(reset), .start_req(start_req), .end_req(end_req),
    .read_req(read_req), .read_vaild(read_vaild), .read_data(read_data),
    .datain_uarto(datain_uarto), .wrsig_uarto(wrsig_uarto), .idle(idle), .busy(busy),
    .words_sent(words_sent));

  uarto_word_ser #(.WORD_W(32), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0), .ACK_TO(ACK32)) dut32 (
    .clk_150_0(clk_150_0), .reset(reset), .start_req(start32), .end_req(end32),
    .read_req(read_req32), .read_vaild(vaild32), .read_data(data32),
    .datain_uarto(datain32), .wrsig_uarto(wrsig32), .idle(idle32), .busy(busy32),
    .words_sent(words32));

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Data store: answers a pending request in the same cycle it is seen.
  initial begin
    read_vaild = 1'b0;
    read_data  = 16'h0000;
    forever begin
      @(negedge clk_150_0);
      if (!reset) begin
        read_vaild = 1'b0;
      end else if (read_req && store_q.size() > 0) begin
        read_vaild = 1'b1;
        read_data  = store_q.pop_front();
        hs_cnt++;
        hs_cyc = cyc;
      end else if (spurious && !read_req) begin
        read_vaild = 1'b1;
        read_data  = 16'hDEAD;
        spurious   = 1'b0;
      end else begin
        read_vaild = 1'b0;
      end
    end
  end

  // Transmitter: mode 0 drops idle 2 cycles after a strobe for 3 cycles,
  // mode 1 never drops idle, mode 2 holds idle low (stalled).
  initial begin
    int drop_cnt, bsy_cnt;
    drop_cnt = 0;
    bsy_cnt  = 0;
    idle     = 1'b1;
    forever begin
      @(negedge clk_150_0);
      if (!reset || tx_mode == 2) begin
        drop_cnt = 0;
        bsy_cnt  = 0;
        idle     = !reset;
        if (reset) idle = 1'b0;
        if (!reset) idle = 1'b1;
      end else begin
        if (bsy_cnt > 0) bsy_cnt--;
        if (drop_cnt > 0) begin
          drop_cnt--;
          if (drop_cnt == 0) bsy_cnt = 3;
        end
        if (wrsig_uarto && tx_mode == 0) drop_cnt = 2;
        idle = (bsy_cnt == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_150_0);
      if (wrsig_uarto) begin
        strobe_cnt++;
        prev_strobe_cyc = last_strobe_cyc;
        last_strobe_cyc = cyc;
        check("strobe16_width", 32'(prev_wr16), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL byte16: unexpected byte %02h, none queued (cycle %0d)", datain_uarto, cyc);
        end else begin
          check("byte16", 32'(datain_uarto), 32'(exp_q.pop_front()));
        end
      end
      prev_wr16 = wrsig_uarto;
    end
  end

  initial begin
    forever begin
      @(negedge clk_150_0);
      if (wrsig32) begin
        strobe32_cnt++;
        check("strobe32_width", 32'(prev_wr32), 32'd0);
        if (exp32_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL byte32: unexpected byte %02h, none queued (cycle %0d)", datain32, cyc);
        end else begin
          check("byte32", 32'(datain32), 32'(exp32_q.pop_front()));
        end
      end
      prev_wr32 = wrsig32;
    end
  end

  task automatic load16(input logic [15:0] w, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] ck);
    store_q.push_back(w);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    if (CKS != 0) exp_q.push_back(ck);
    words_exp++;
  endtask

  task automatic drain16(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_150_0);
      if (exp_q.size() == 0 && store_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({"drain_", nm}, 32'(ok), 32'd1);
    repeat (8) @(negedge clk_150_0);
  endtask

  task automatic wait_strobes(input int target, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_150_0);
      #1;
      if (strobe_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check({"wait_", nm}, 32'(ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, h0, w0;
    bit ok;

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A, 8'hFF};
    vecs[1] = '{16'h1234, 8'h12, 8'h34, 8'h26};
    vecs[2] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00};
    vecs[4] = '{16'h00FF, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{16'h8001, 8'h80, 8'h01, 8'h81};

    reset = 1'b0;
    start_req = 1'b0; end_req = 1'b0;
    start32 = 1'b0; end32 = 1'b0; vaild32 = 1'b0; data32 = 32'h0; idle32 = 1'b1;
    repeat (3) @(posedge clk_150_0);
    #1;
    check("rst_read_req", 32'(read_req), 32'd0);
    check("rst_wrsig", 32'(wrsig_uarto), 32'd0);
    check("rst_datain", 32'(datain_uarto), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    @(negedge clk_150_0);
    reset = 1'b1;

    // First word into an empty FIFO: strobe 3 cycles after the valid pulse.
    start_req = 1'b1;
    repeat (3) @(negedge clk_150_0);
    check("read_req_run", 32'(read_req), 32'd1);
    s0 = strobe_cnt;
    load16(vecs[0].word, vecs[0].b0, vecs[0].b1, vecs[0].cks);
    wait_strobes(s0 + 1, "first_strobe");
    check("latency", 32'(last_strobe_cyc - hs_cyc), 32'd3);
    drain16("first");
    check("words_first", 32'(words_sent), 32'(words_exp));
    check("read_req_reassert", 32'(read_req), 32'd1);

    // A valid without a request must be ignored.
    start_req = 1'b0;
    repeat (2) @(negedge clk_150_0);
    check("read_req_stopped", 32'(read_req), 32'd0);
    spurious = 1'b1;
    repeat (4) @(negedge clk_150_0);
    start_req = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load16(vecs[i].word, vecs[i].b0, vecs[i].b1, vecs[i].cks);
      drain16("table");
      check("words_table", 32'(words_sent), 32'(words_exp));
    end

    // Idle never drops: each byte waits out the full acknowledge timeout.
    tx_mode = 1;
    load16(16'h1357, 8'h13, 8'h57, 8'h44);
    drain16("ack_timeout");
    check("ack_timeout_gap", 32'(last_strobe_cyc - prev_strobe_cyc), 32'(ACK16 + 2));
    tx_mode = 0;

    // Stalled transmitter: FIFO fills plus one word held in the shift register.
    tx_mode = 2;
    h0 = hs_cnt;
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] w;
      w = 16'h0101 * 16'(i + 1) + 16'h1000;
      load16(w, w[15:8], w[7:0], w[15:8] ^ w[7:0]);
    end
    repeat (40) @(negedge clk_150_0);
    check("stall_read_req", 32'(read_req), 32'd0);
    check("stall_pushes", 32'(hs_cnt - h0), 32'(DEPTH + 1));
    check("stall_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    tx_mode = 0;
    drain16("stall");
    check("words_stall", 32'(words_sent), 32'(words_exp));

    // Stop mid-word: the word completes, queued words wait for run.
    w0 = words_exp;
    s0 = strobe_cnt;
    load16(16'hBEEF, 8'hBE, 8'hEF, 8'h51);
    load16(16'h1111, 8'h11, 8'h11, 8'h00);
    load16(16'h2222, 8'h22, 8'h22, 8'h00);
    wait_strobes(s0 + 1, "stop_first");
    end_req = 1'b1;
    wait_strobes(s0 + 2 + CKS, "stop_finish");
    repeat (30) @(negedge clk_150_0);
    check("stop_no_more", 32'(strobe_cnt - s0), 32'(2 + CKS));
    check("stop_read_req", 32'(read_req), 32'd0);
    check("stop_busy", 32'(busy), 32'd1);
    check("stop_words", 32'(words_sent), 32'(w0 + 1));
    end_req = 1'b0;
    drain16("resume");
    check("words_resume", 32'(words_sent), 32'(words_exp));

    // Asynchronous reset during a strobe clears everything at once.
    s0 = strobe_cnt;
    load16(16'h5AA5, 8'h5A, 8'hA5, 8'hFF);
    wait_strobes(s0 + 1, "reset_strobe");
    reset = 1'b0;
    #1;
    check("arst_wrsig", 32'(wrsig_uarto), 32'd0);
    check("arst_datain", 32'(datain_uarto), 32'd0);
    check("arst_read_req", 32'(read_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_words", 32'(words_sent), 32'd0);
    exp_q.delete();
    store_q.delete();
    words_exp = 0;
    @(negedge clk_150_0);
    reset = 1'b1;
    load16(16'h0F0F, 8'h0F, 8'h0F, 8'h00);
    drain16("after_reset");
    check("words_after_reset", 32'(words_sent), 32'(words_exp));

    // 32-bit LSB-first instance.
    start32 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_150_0);
      if (read_req32) begin
        ok = 1'b1;
        break;
      end
    end
    check("req32", 32'(ok), 32'd1);
    vaild32 = 1'b1;
    data32  = 32'h11223344;
    exp32_q.push_back(8'h44);
    exp32_q.push_back(8'h33);
    exp32_q.push_back(8'h22);
    exp32_q.push_back(8'h11);
    if (CKS != 0) exp32_q.push_back(8'h44);
    @(negedge clk_150_0);
    vaild32 = 1'b0;
    repeat (80) @(negedge clk_150_0);
    check("strobes32", 32'(strobe32_cnt), 32'(4 + CKS));
    check("exp32_left", 32'(exp32_q.size()), 32'd0);
    check("words32", 32'(words32), 32'd1);
    check("busy32", 32'(busy32), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
